// File: rtl/sram_arb_pkg.sv
// Shared defaults and types for the 1rw1r SRAM arbiter.
// SRAM_ARB_RDATA_REG_EN selects the registered-response (latency 2) build.
package sram_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_WMASKS = DEF_DATA_WIDTH / 8;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

`ifdef SRAM_ARB_RDATA_REG_EN
  localparam int READ_LATENCY = 2;
`else
  localparam int READ_LATENCY = 1;
`endif

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-input round-robin grant for macro port 0; a grant is an accept.
module sram_rr_arb2
  import sram_arb_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  req_id_e last_grant_q, last_grant_d;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!reset) begin
      if (req_a && req_b) begin
        gnt_a = (last_grant_q == REQ_B);
        gnt_b = (last_grant_q == REQ_A);
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt_a) last_grant_d = REQ_A;
    else if (gnt_b) last_grant_d = REQ_B;
  end

  // Starting from B means A wins the first contention.
  always_ff @(posedge clock) begin
    if (reset) last_grant_q <= REQ_B;
    else       last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/sram_1rw1r_arbiter.sv
// Sequences a 1rw1r SRAM macro for requesters A/B (port 0) and C (port 1).
// Define SRAM_ARB_RDATA_REG_EN to register the read responses (latency 2).
module sram_1rw1r_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_WMASKS = DEF_NUM_WMASKS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [NUM_WMASKS-1:0] a_req_wmask,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rsp_rdata,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_we,
  input  logic [NUM_WMASKS-1:0] b_req_wmask,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rsp_rdata,
  input  logic                  c_req_valid,
  output logic                  c_req_ready,
  input  logic [ADDR_WIDTH-1:0] c_req_addr,
  output logic                  c_rsp_valid,
  output logic [DATA_WIDTH-1:0] c_rsp_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  logic    gnt_a, gnt_b;
  logic    p0_acc, p0_wr_acc, c_acc;
  logic    p0_rd_vld_q, p0_rd_vld_d;
  logic    c_rd_vld_q, c_rd_vld_d;
  req_id_e p0_owner_q, p0_owner_d;

  sram_rr_arb2 u_arb (
    .clock (clock),
    .reset (reset),
    .req_a (a_req_valid),
    .req_b (b_req_valid),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  assign a_req_ready = gnt_a;
  assign b_req_ready = gnt_b;
  assign p0_acc      = gnt_a || gnt_b;

  always_comb begin
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = '0;
    sram_addr0  = '0;
    sram_din0   = '0;
    p0_wr_acc   = 1'b0;
    if (gnt_a) begin
      sram_csb0   = 1'b0;
      sram_web0   = !a_req_we;
      sram_wmask0 = a_req_we ? a_req_wmask : '0;
      sram_addr0  = a_req_addr;
      sram_din0   = a_req_wdata;
      p0_wr_acc   = a_req_we;
    end else if (gnt_b) begin
      sram_csb0   = 1'b0;
      sram_web0   = !b_req_we;
      sram_wmask0 = b_req_we ? b_req_wmask : '0;
      sram_addr0  = b_req_addr;
      sram_din0   = b_req_wdata;
      p0_wr_acc   = b_req_we;
    end
  end

  // A same-address port-0 write wins; C retries next cycle and sees the new word.
  always_comb begin
    c_req_ready = !reset;
    if (p0_wr_acc && c_req_valid && (sram_addr0 == c_req_addr)) c_req_ready = 1'b0;
    c_acc      = c_req_valid && c_req_ready;
    sram_csb1  = !c_acc;
    sram_addr1 = c_acc ? c_req_addr : '0;
  end

  always_comb begin
    p0_rd_vld_d = p0_acc && !p0_wr_acc;
    p0_owner_d  = gnt_b ? REQ_B : REQ_A;
    c_rd_vld_d  = c_acc;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p0_rd_vld_q <= 1'b0;
      p0_owner_q  <= REQ_A;
      c_rd_vld_q  <= 1'b0;
    end else begin
      p0_rd_vld_q <= p0_rd_vld_d;
      p0_owner_q  <= p0_owner_d;
      c_rd_vld_q  <= c_rd_vld_d;
    end
  end

`ifdef SRAM_ARB_RDATA_REG_EN
  logic                  a_rsp_valid_q, a_rsp_valid_d;
  logic                  b_rsp_valid_q, b_rsp_valid_d;
  logic                  c_rsp_valid_q, c_rsp_valid_d;
  logic [DATA_WIDTH-1:0] a_rsp_rdata_q, a_rsp_rdata_d;
  logic [DATA_WIDTH-1:0] b_rsp_rdata_q, b_rsp_rdata_d;
  logic [DATA_WIDTH-1:0] c_rsp_rdata_q, c_rsp_rdata_d;

  always_comb begin
    a_rsp_valid_d = p0_rd_vld_q && (p0_owner_q == REQ_A);
    b_rsp_valid_d = p0_rd_vld_q && (p0_owner_q == REQ_B);
    c_rsp_valid_d = c_rd_vld_q;
    a_rsp_rdata_d = a_rsp_valid_d ? sram_dout0 : '0;
    b_rsp_rdata_d = b_rsp_valid_d ? sram_dout0 : '0;
    c_rsp_rdata_d = c_rsp_valid_d ? sram_dout1 : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
      c_rsp_valid_q <= 1'b0;
      a_rsp_rdata_q <= '0;
      b_rsp_rdata_q <= '0;
      c_rsp_rdata_q <= '0;
    end else begin
      a_rsp_valid_q <= a_rsp_valid_d;
      b_rsp_valid_q <= b_rsp_valid_d;
      c_rsp_valid_q <= c_rsp_valid_d;
      a_rsp_rdata_q <= a_rsp_rdata_d;
      b_rsp_rdata_q <= b_rsp_rdata_d;
      c_rsp_rdata_q <= c_rsp_rdata_d;
    end
  end

  // Reset masks a response already sitting in the output stage.
  always_comb begin
    a_rsp_valid = a_rsp_valid_q && !reset;
    b_rsp_valid = b_rsp_valid_q && !reset;
    c_rsp_valid = c_rsp_valid_q && !reset;
    a_rsp_rdata = a_rsp_valid ? a_rsp_rdata_q : '0;
    b_rsp_rdata = b_rsp_valid ? b_rsp_rdata_q : '0;
    c_rsp_rdata = c_rsp_valid ? c_rsp_rdata_q : '0;
  end
`else
  // Macro dout settles mid-cycle, so it is routed straight through.
  always_comb begin
    a_rsp_valid = p0_rd_vld_q && (p0_owner_q == REQ_A) && !reset;
    b_rsp_valid = p0_rd_vld_q && (p0_owner_q == REQ_B) && !reset;
    c_rsp_valid = c_rd_vld_q && !reset;
    a_rsp_rdata = a_rsp_valid ? sram_dout0 : '0;
    b_rsp_rdata = b_rsp_valid ? sram_dout0 : '0;
    c_rsp_rdata = c_rsp_valid ? sram_dout1 : '0;
  end
`endif

endmodule

// File: tb/tb_sram_1rw1r_arbiter.sv
// Directed bench for sram_1rw1r_arbiter with a behavioural SRAM macro and a
// per-cycle reference model of arbitration, collisions and read responses.
module tb_sram_1rw1r_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MW = 4;
`ifdef SRAM_ARB_RDATA_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
  logic [MW-1:0] a_req_wmask;
  logic [AW-1:0] a_req_addr;
  logic [DW-1:0] a_req_wdata, a_rsp_rdata;
  logic          b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
  logic [MW-1:0] b_req_wmask;
  logic [AW-1:0] b_req_addr;
  logic [DW-1:0] b_req_wdata, b_rsp_rdata;
  logic          c_req_valid, c_req_ready, c_rsp_valid;
  logic [AW-1:0] c_req_addr;
  logic [DW-1:0] c_rsp_rdata;
  logic          sram_csb0, sram_web0, sram_csb1;
  logic [MW-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout0 = '0;
  logic [DW-1:0] sram_dout1 = '0;

  always #5 clock = ~clock;

  sram_1rw1r_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW)) dut (
    .clock(clock), .reset(reset),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_wmask(a_req_wmask), .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_wmask(b_req_wmask), .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_addr(c_req_addr),
    .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  // Behavioural macro: inputs captured at the edge, dout updated right after it.
  logic [DW-1:0] macro_mem [256];
  logic [DW-1:0] macro_w;
  initial for (int i = 0; i < 256; i++) macro_mem[i] = '0;

  always @(posedge clock) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        macro_w = macro_mem[sram_addr0];
        for (int i = 0; i < MW; i++)
          if (sram_wmask0[i]) macro_w[8*i +: 8] = sram_din0[8*i +: 8];
        macro_mem[sram_addr0] <= macro_w;
      end else begin
        sram_dout0 <= macro_mem[sram_addr0];
      end
    end
    if (!sram_csb1) sram_dout1 <= macro_mem[sram_addr1];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %b required %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: expected responses are queued with the cycle they are due.
  typedef struct {
    int            due;
    int            who;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          pend[$];
  logic [DW-1:0] ref_mem [256];
  bit            last_was_b;

  initial begin : model
    bit            ga, gb, acc, cacc, cr;
    bit            we;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    logic [MW-1:0] wm;
    bit            va, vb, vc;
    logic [DW-1:0] ea, eb, ec;
    last_was_b = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    forever begin
      @(negedge clock);
      ga   = !reset && a_req_valid && (!b_req_valid || last_was_b);
      gb   = !reset && b_req_valid && (!a_req_valid || !last_was_b);
      acc  = ga || gb;
      we   = ga ? a_req_we    : gb ? b_req_we    : 1'b0;
      ad   = ga ? a_req_addr  : gb ? b_req_addr  : '0;
      wd   = ga ? a_req_wdata : gb ? b_req_wdata : '0;
      wm   = ga ? a_req_wmask : gb ? b_req_wmask : '0;
      cr   = !reset && !(acc && we && c_req_valid && (ad == c_req_addr));
      cacc = c_req_valid && cr;
      va = 0; vb = 0; vc = 0; ea = '0; eb = '0; ec = '0;
      foreach (pend[i]) begin
        if (!reset && pend[i].due == cyc) begin
          if (pend[i].who == 0) begin va = 1; ea = pend[i].data; end
          if (pend[i].who == 1) begin vb = 1; eb = pend[i].data; end
          if (pend[i].who == 2) begin vc = 1; ec = pend[i].data; end
        end
      end
      chk1("a_req_ready", a_req_ready, ga);
      chk1("b_req_ready", b_req_ready, gb);
      chk1("c_req_ready", c_req_ready, cr);
      chk1("sram_csb0", sram_csb0, !acc);
      chk1("sram_web0", sram_web0, !(acc && we));
      chk("sram_wmask0", 32'(sram_wmask0), (acc && we) ? 32'(wm) : 32'd0);
      chk("sram_addr0", 32'(sram_addr0), 32'(ad));
      chk("sram_din0", sram_din0, wd);
      chk1("sram_csb1", sram_csb1, !cacc);
      if (cacc) chk("sram_addr1", 32'(sram_addr1), 32'(c_req_addr));
      chk1("a_rsp_valid", a_rsp_valid, va);
      chk1("b_rsp_valid", b_rsp_valid, vb);
      chk1("c_rsp_valid", c_rsp_valid, vc);
      chk("a_rsp_rdata", a_rsp_rdata, ea);
      chk("b_rsp_rdata", b_rsp_rdata, eb);
      chk("c_rsp_rdata", c_rsp_rdata, ec);
      @(posedge clock);
      if (reset) begin
        pend.delete();
        last_was_b = 1'b1;
      end else begin
        if (cacc) pend.push_back('{due: cyc + LAT, who: 2, data: ref_mem[c_req_addr]});
        if (acc) begin
          last_was_b = gb;
          if (we) begin
            for (int i = 0; i < MW; i++)
              if (wm[i]) ref_mem[ad][8*i +: 8] = wd[8*i +: 8];
          end else begin
            pend.push_back('{due: cyc + LAT, who: gb ? 1 : 0, data: ref_mem[ad]});
          end
        end
        while (pend.size() > 0 && pend[0].due <= cyc) pend.pop_front();
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    a_req_valid = 0; a_req_we = 0; a_req_wmask = '0; a_req_addr = '0; a_req_wdata = '0;
    b_req_valid = 0; b_req_we = 0; b_req_wmask = '0; b_req_addr = '0; b_req_wdata = '0;
    c_req_valid = 0; c_req_addr = '0;
  endtask

  task automatic set_a(input logic v, input logic w, input logic [MW-1:0] m,
                       input logic [AW-1:0] ad, input logic [DW-1:0] d);
    a_req_valid = v; a_req_we = w; a_req_wmask = m; a_req_addr = ad; a_req_wdata = d;
  endtask

  task automatic set_b(input logic v, input logic w, input logic [MW-1:0] m,
                       input logic [AW-1:0] ad, input logic [DW-1:0] d);
    b_req_valid = v; b_req_we = w; b_req_wmask = m; b_req_addr = ad; b_req_wdata = d;
  endtask

  task automatic set_c(input logic v, input logic [AW-1:0] ad);
    c_req_valid = v; c_req_addr = ad;
  endtask

  task automatic wait_rsp();
    step();
    idle();
    for (int i = 1; i < LAT; i++) step();
    @(negedge clock);
  endtask

  initial begin : stim
    reset = 1'b1;
    idle();
    set_a(1, 0, '0, 8'h05, '0);
    set_b(1, 0, '0, 8'h06, '0);
    set_c(1, 8'h07);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk1("rst_a_ready", a_req_ready, 1'b0);
      chk1("rst_csb0", sram_csb0, 1'b1);
      chk1("rst_csb1", sram_csb1, 1'b1);
      step();
    end
    reset = 1'b0;
    idle();
    step();

    // A write 0x10 then A read 0x10
    set_a(1, 1, 4'b1111, 8'h10, 32'hDEADBEEF);
    step();
    set_a(1, 0, 4'b0000, 8'h10, '0);
    @(negedge clock);
    chk1("rd_a_ready", a_req_ready, 1'b1);
    wait_rsp();
    chk1("rd_a_rsp_valid", a_rsp_valid, 1'b1);
    chk("rd_a_rsp_rdata", a_rsp_rdata, 32'hDEADBEEF);
    chk1("rd_b_rsp_valid", b_rsp_valid, 1'b0);
    step();
    @(negedge clock);
    chk1("rd_a_rsp_once", a_rsp_valid, 1'b0);

    // Byte-masked write by A, read back by B
    step();
    set_a(1, 1, 4'b0100, 8'h10, 32'h00AA0000);
    step();
    idle();
    set_b(1, 0, 4'b0000, 8'h10, '0);
    wait_rsp();
    chk("mask_b_rdata", b_rsp_rdata, 32'hDEAABEEF);
    chk1("mask_a_valid", a_rsp_valid, 1'b0);

    // Contention: B preloads 0x01/0x02, then A and B both read for 4 cycles
    step();
    set_b(1, 1, 4'b1111, 8'h01, 32'h11111111);
    step();
    set_b(1, 1, 4'b1111, 8'h02, 32'h22222222);
    step();
    set_a(1, 0, 4'b0000, 8'h01, '0);
    set_b(1, 0, 4'b0000, 8'h02, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk1("cont_a_ready", a_req_ready, (k % 2) == 0);
      chk1("cont_b_ready", b_req_ready, (k % 2) == 1);
      chk("cont_a_rsp", a_rsp_rdata, (k >= LAT && ((k - LAT) % 2) == 0) ? 32'h11111111 : 32'h0);
      step();
    end
    idle();
    step();

    // Collision: A writes 0x20 while C reads 0x20
    set_a(1, 1, 4'b1111, 8'h20, 32'h12345678);
    set_c(1, 8'h20);
    @(negedge clock);
    chk1("coll_c_stall", c_req_ready, 1'b0);
    chk1("coll_a_ready", a_req_ready, 1'b1);
    step();
    set_a(0, 0, 4'b0000, 8'h00, '0);
    @(negedge clock);
    chk1("coll_c_retry", c_req_ready, 1'b1);
    wait_rsp();
    chk1("coll_c_valid", c_rsp_valid, 1'b1);
    chk("coll_c_rdata", c_rsp_rdata, 32'h12345678);

    // Same-address port-0 read and different-address write do not stall C
    step();
    set_a(1, 0, 4'b0000, 8'h20, '0);
    set_c(1, 8'h20);
    @(negedge clock);
    chk1("rd_same_c_ready", c_req_ready, 1'b1);
    step();
    set_a(1, 1, 4'b1111, 8'h30, 32'hCAFEF00D);
    set_c(1, 8'h31);
    @(negedge clock);
    chk1("wr_diff_c_ready", c_req_ready, 1'b1);
    step();

    // Back-to-back mixed traffic on both ports
    for (int k = 0; k < 8; k++) begin
      set_a(1, (k % 3) == 0, (k == 3) ? 4'b0000 : 4'b1111, 8'(8'h40 + k), 32'hA0000000 + k);
      set_b((k % 2) == 1, 0, 4'b0000, 8'(8'h3F + k), '0);
      set_c(1, 8'(8'h40 + k));
      step();
    end
    idle();
    repeat (3) step();

    // Reset one cycle after a read is accepted: the response must be lost
    set_a(1, 0, 4'b0000, 8'h10, '0);
    step();
    idle();
    reset = 1'b1;
    @(negedge clock);
    chk1("midrst_a_valid_n1", a_rsp_valid, 1'b0);
    step();
    reset = 1'b0;
    @(negedge clock);
    chk1("midrst_a_valid_n2", a_rsp_valid, 1'b0);
    step();
    set_a(1, 0, 4'b0000, 8'h10, '0);
    set_b(1, 0, 4'b0000, 8'h20, '0);
    @(negedge clock);
    chk1("post_rst_a_first", a_req_ready, 1'b1);
    wait_rsp();
    chk1("post_rst_a_valid", a_rsp_valid, 1'b1);
    chk("post_rst_a_rdata", a_rsp_rdata, 32'hDEAABEEF);
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
